// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks the rd write value by opcode, extracts and
// extends load data, suppresses x0 writes and flags misaligned loads. The
// result is captured into a 2-entry skid buffer so the register-file side
// can stall without losing results. Also counts retired register writes.
module wb_select_stage #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int CNT_W      = 16,
  parameter int LOAD_ALIGN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [AW-1:0]    rd_addr,
  input  logic             reg_write,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_imm,
  input  logic [XLEN-1:0]  pc4,
  input  logic [XLEN-1:0]  immediate,
  input  logic [XLEN-1:0]  load_data,
  input  logic [1:0]       addr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_we,
  output logic [AW-1:0]    out_rd_addr,
  output logic [XLEN-1:0]  out_data,
  output logic             out_misalign,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LOAD  = 5'b00000;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    logic            mis;
  } entry_t;

  logic [1:0]      state;
  entry_t          head, tail, nxt;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  logic            ld_mis;
  logic            is_mis;
  logic            acc, pop;

  assign ld_b = load_data[{addr_lo, 3'b000} +: 8];
  assign ld_h = load_data[{addr_lo[1], 4'b0000} +: 16];

  // Load extract/extend and alignment check; without LOAD_ALIGN the word
  // passes through untouched and is never flagged.
  always_comb begin
    ld_val = load_data;
    ld_mis = 1'b0;
    if (LOAD_ALIGN != 0) begin
      case (funct3)
        3'b000: ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
        3'b001: begin
          ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
          ld_mis = addr_lo[0];
        end
        3'b010: ld_mis = (addr_lo != 2'b00);
        3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_b};
        3'b101: begin
          ld_val = {{(XLEN-16){1'b0}}, ld_h};
          ld_mis = addr_lo[0];
        end
        default: ld_val = load_data;
      endcase
    end
  end

  // Source select and write-enable qualification for the incoming result.
  always_comb begin
    nxt    = '0;
    is_mis = 1'b0;
    case (opcode)
      OP_LUI:          nxt.data = immediate;
      OP_AUIPC:        nxt.data = pc_imm;
      OP_JAL, OP_JALR: nxt.data = pc4;
      OP_LOAD: begin
        is_mis   = ld_mis;
        nxt.data = ld_mis ? '0 : ld_val;
      end
      default:         nxt.data = alu_result;
    endcase
    nxt.mis = is_mis;
    nxt.rd  = rd_addr;
    nxt.we  = reg_write & (rd_addr != '0) & ~is_mis;
  end

  // Ready depends only on buffer occupancy (and reset), never on out_ready.
  assign in_ready     = rst & (state != S_FULL);
  assign out_valid    = (state != S_EMPTY);
  assign acc          = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign out_we       = head.we;
  assign out_rd_addr  = head.rd;
  assign out_data     = head.data;
  assign out_misalign = head.mis;

  // Skid buffer: head drives the outputs, tail holds the overflow entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        S_EMPTY: if (acc) begin
          head  <= nxt;
          state <= S_ONE;
        end
        S_ONE: begin
          if (acc && pop) begin
            head <= nxt;
          end else if (acc) begin
            tail  <= nxt;
            state <= S_FULL;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_FULL: if (pop) begin
          head  <= tail;
          state <= S_ONE;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Saturating count of retired register writes.
  always_ff @(posedge clk) begin
    if (!rst) retired_cnt <= '0;
    else if (pop && head.we && (retired_cnt != '1)) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Randomized + directed bench for wb_select_stage. A queue-based model of the
// two-entry buffer predicts outputs; a second instance with CNT_W=2 covers
// counter saturation.
module tb_wb_select_stage;

  localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101, JAL = 5'b11011,
                         JALR = 5'b11001, LOAD = 5'b00000, ALU = 5'b01100;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, reg_write = 1'b0;
  logic [4:0]  opcode = '0, rd_addr = '0;
  logic [2:0]  funct3 = '0;
  logic [1:0]  addr_lo = '0;
  logic [31:0] alu_result = '0, pc_imm = '0, pc4 = '0, immediate = '0, load_data = '0;

  logic        in_ready, out_valid, out_we, out_misalign;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_data;
  logic [15:0] retired_cnt;
  logic        in_ready_b, out_valid_b, out_we_b, out_misalign_b;
  logic [4:0]  out_rd_addr_b;
  logic [31:0] out_data_b;
  logic [1:0]  retired_cnt_b;

  int vectors = 0;
  int errors  = 0;

  exp_t        q[$];
  logic [15:0] exp_cnt  = '0;
  logic [1:0]  exp_cnt2 = '0;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr), .reg_write(reg_write),
    .alu_result(alu_result), .pc_imm(pc_imm), .pc4(pc4), .immediate(immediate),
    .load_data(load_data), .addr_lo(addr_lo), .out_valid(out_valid),
    .out_ready(out_ready), .out_we(out_we), .out_rd_addr(out_rd_addr),
    .out_data(out_data), .out_misalign(out_misalign), .retired_cnt(retired_cnt)
  );

  wb_select_stage #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .opcode(opcode), .funct3(funct3), .rd_addr(rd_addr), .reg_write(reg_write),
    .alu_result(alu_result), .pc_imm(pc_imm), .pc4(pc4), .immediate(immediate),
    .load_data(load_data), .addr_lo(addr_lo), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_we(out_we_b), .out_rd_addr(out_rd_addr_b),
    .out_data(out_data_b), .out_misalign(out_misalign_b), .retired_cnt(retired_cnt_b)
  );

  // Expected entry from the current inputs, straight from the opcode/funct3 rules.
  function automatic exp_t ref_entry();
    exp_t        e;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    logic        mis;
    int          sb, sh;
    b   = 8'(load_data >> (8 * addr_lo));
    h   = 16'(load_data >> (16 * addr_lo[1]));
    sb  = int'($signed(b));
    sh  = int'($signed(h));
    mis = 1'b0;
    case (opcode)
      LUI:       v = immediate;
      AUIPC:     v = pc_imm;
      JAL, JALR: v = pc4;
      LOAD: begin
        case (funct3)
          3'd0:    v = sb;
          3'd1:    v = sh;
          3'd4:    v = 32'(b);
          3'd5:    v = 32'(h);
          default: v = load_data;
        endcase
        mis = ((funct3 == 3'd1 || funct3 == 3'd5) && addr_lo % 2 == 1) ||
              (funct3 == 3'd2 && addr_lo != 0);
      end
      default:   v = alu_result;
    endcase
    if (mis) v = 0;
    e.we   = reg_write && rd_addr != 0 && !mis;
    e.rd   = rd_addr;
    e.data = v;
    e.mis  = mis;
    return e;
  endfunction

  // Advance the model across the coming rising edge, then wait for the next negedge.
  task automatic step();
    bit acc, pop;
    acc = in_valid && rst && q.size() < 2;
    pop = rst && q.size() > 0 && out_ready;
    if (!rst) begin
      q.delete();
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else begin
      if (pop) begin
        if (q[0].we) begin
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_entry());
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    alu_result = $urandom;
    pc_imm     = $urandom;
    pc4        = $urandom;
    immediate  = $urandom;
    load_data  = $urandom;
    addr_lo    = 2'($urandom_range(0, 3));
    funct3     = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_data();
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid act=%b exp=0", out_valid); end
    vectors++; if (out_we !== 1'b0) begin errors++; $display("FAIL rst_we act=%b exp=0", out_we); end
    vectors++; if (out_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_rd act=%h exp=0", out_rd_addr); end
    vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data act=%h exp=0", out_data); end
    vectors++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL rst_mis act=%b exp=0", out_misalign); end
    vectors++; if (retired_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt act=%0d exp=0", retired_cnt); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready act=%b exp=0", in_ready); end
    rst = 1'b1;
    step();
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready act=%b exp=1", in_ready); end
  endtask

  task automatic test_cnt_sat();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data(); opcode = ALU; rd_addr = 5'(i + 1); reg_write = 1'b1; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    vectors++; if (retired_cnt !== 16'd5) begin errors++; $display("FAIL cnt16 act=%0d exp=5", retired_cnt); end
    vectors++; if (retired_cnt_b !== 2'd3) begin errors++; $display("FAIL cnt2_sat act=%0d exp=3", retired_cnt_b); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cnt_drain act=%b exp=0", out_valid); end
    // fill the buffer, then reset it while full
    out_ready = 1'b0; in_valid = 1'b1; rand_data(); opcode = ALU; rd_addr = 5'd3;
    step(); step();
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready act=%b exp=0", in_ready); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid act=%b exp=1", out_valid); end
    in_valid = 1'b0; rst = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid act=%b exp=0", out_valid); end
    vectors++; if (retired_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt act=%0d exp=0", retired_cnt); end
    vectors++; if (retired_cnt_b !== 2'd0) begin errors++; $display("FAIL midrst_cnt2 act=%0d exp=0", retired_cnt_b); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready act=%b exp=0", in_ready); end
    rst = 1'b1;
    step();
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL after_midrst rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_lui();
    out_ready = 1'b1; rand_data();
    opcode = LUI; immediate = 32'h12345000; rd_addr = 5'd5; reg_write = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lui_valid act=%b exp=1", out_valid); end
    vectors++; if (out_data !== 32'h12345000) begin errors++; $display("FAIL lui_data act=%h exp=12345000", out_data); end
    vectors++; if (out_we !== 1'b1 || out_rd_addr !== 5'd5) begin errors++; $display("FAIL lui_we_rd act=%b/%0d exp=1/5", out_we, out_rd_addr); end
    step();
    vectors++; if (retired_cnt !== exp_cnt) begin errors++; $display("FAIL lui_cnt act=%0d exp=%0d", retired_cnt, exp_cnt); end
    // AUIPC takes pc_imm
    rand_data(); opcode = AUIPC; pc_imm = 32'hCAFE0010; rd_addr = 5'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 32'hCAFE0010) begin errors++; $display("FAIL auipc_data act=%h exp=cafe0010", out_data); end
    step();
  endtask

  task automatic test_load();
    logic [2:0]  f3s[5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ads[5]  = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FF7F, 32'h80FFFF7F};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      opcode = LOAD; load_data = 32'h80FFFF7F; funct3 = f3s[i]; addr_lo = ads[i];
      rd_addr = 5'd12; reg_write = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++; if (out_data !== exps[i] || out_we !== 1'b1 || out_misalign !== 1'b0)
        begin errors++; $display("FAIL load_f3_%0d act=%h we=%b mis=%b exp=%h we=1 mis=0", f3s[i], out_data, out_we, out_misalign, exps[i]); end
      step();
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3s[3] = '{3'd1, 3'd5, 3'd2};
    logic [1:0]  ads[3] = '{2'd1, 2'd3, 2'd2};
    logic [15:0] cnt_before;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      opcode = LOAD; funct3 = f3s[i]; addr_lo = ads[i]; rd_addr = 5'd4; reg_write = 1'b1; in_valid = 1'b1;
      cnt_before = exp_cnt;
      step();
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_we !== 1'b0 || out_data !== 32'd0)
        begin errors++; $display("FAIL misalign_%0d vld=%b mis=%b we=%b data=%h exp 1/1/0/0", i, out_valid, out_misalign, out_we, out_data); end
      step();
      vectors++; if (retired_cnt !== cnt_before) begin errors++; $display("FAIL misalign_cnt act=%0d exp=%0d", retired_cnt, cnt_before); end
    end
  endtask

  task automatic test_jal();
    out_ready = 1'b1; rand_data();
    opcode = JAL; pc4 = 32'h104; rd_addr = 5'd0; reg_write = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_we !== 1'b0) begin errors++; $display("FAIL jal_x0 vld=%b we=%b exp 1/0", out_valid, out_we); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_x0_pop act=%b exp=0", out_valid); end
    rand_data(); opcode = JALR; pc4 = 32'h104; rd_addr = 5'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 32'h104 || out_we !== 1'b1) begin errors++; $display("FAIL jalr act=%h we=%b exp=104 we=1", out_data, out_we); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; opcode = ALU; reg_write = 1'b1; in_valid = 1'b1;
    rand_data(); alu_result = 32'hA0; rd_addr = 5'd7;
    step();
    vectors++; if (in_ready !== 1'b1 || out_rd_addr !== 5'd7) begin errors++; $display("FAIL b2b_1 rdy=%b rd=%0d exp 1/7", in_ready, out_rd_addr); end
    alu_result = 32'hB0; rd_addr = 5'd8;
    step();
    vectors++; if (in_ready !== 1'b0 || out_rd_addr !== 5'd7) begin errors++; $display("FAIL b2b_2 rdy=%b rd=%0d exp 0/7", in_ready, out_rd_addr); end
    alu_result = 32'hC0; rd_addr = 5'd9;
    step();
    vectors++; if (in_ready !== 1'b0 || out_data !== 32'hA0) begin errors++; $display("FAIL b2b_stall rdy=%b data=%h exp 0/a0", in_ready, out_data); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_data !== 32'hB0 || out_rd_addr !== 5'd8 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_B data=%h rd=%0d rdy=%b exp b0/8/1", out_data, out_rd_addr, in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 32'hC0 || out_rd_addr !== 5'd9) begin errors++; $display("FAIL b2b_C data=%h rd=%0d exp c0/9", out_data, out_rd_addr); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty act=%b exp=0", out_valid); end
  endtask

  task automatic test_random(input int n);
    logic [4:0] ops[6] = '{LUI, AUIPC, JAL, JALR, LOAD, ALU};
    int         k;
    for (int i = 0; i < n; i++) begin
      rand_data();
      k = int'($urandom_range(0, 6));
      opcode    = (k == 6) ? 5'($urandom) : ops[k];
      rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      reg_write = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) > 1);
      step();
      vectors++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid i=%0d act=%b exp=%b", i, out_valid, q.size() != 0); end
      vectors++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready i=%0d act=%b exp=%b", i, in_ready, q.size() < 2); end
      if (q.size() != 0) begin
        vectors++; if ({out_we, out_rd_addr, out_data, out_misalign} !== q[0])
          begin errors++; $display("FAIL rnd_head i=%0d act=%b/%0d/%h/%b exp=%b/%0d/%h/%b", i, out_we, out_rd_addr, out_data, out_misalign, q[0].we, q[0].rd, q[0].data, q[0].mis); end
      end
      vectors++; if (retired_cnt !== exp_cnt || retired_cnt_b !== exp_cnt2)
        begin errors++; $display("FAIL rnd_cnt i=%0d act=%0d/%0d exp=%0d/%0d", i, retired_cnt, retired_cnt_b, exp_cnt, exp_cnt2); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cnt_sat();
    test_lui();
    test_load();
    test_misalign();
    test_jal();
    test_back_to_back();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
